// File: rtl/fsm_mem_access_pkg.sv
// Shared encodings for the memory-access control FSM: state codes, decode bit
// positions, FP opcodes, access sizes and the latched per-instruction fields.
package fsm_mem_access_pkg;

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_EXECUTE   = 4'd2;
  localparam logic [3:0] S_ALIGN     = 4'd3;
  localparam logic [3:0] S_MEM_STORE = 4'd4;
  localparam logic [3:0] S_MEM_LOAD  = 4'd5;
  localparam logic [3:0] S_WRITEBACK = 4'd6;
  localparam logic [3:0] S_DONE      = 4'd7;
  localparam logic [3:0] S_FAULT     = 4'd8;

  localparam int CODE_LOAD  = 0;
  localparam int CODE_STORE = 8;
  localparam int CODE_LUI   = 13;

  localparam logic [6:0] OP_FP_LOAD  = 7'b0000111;
  localparam logic [6:0] OP_FP_STORE = 7'b0100111;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_D = 2'b11;

  typedef struct packed {
    logic [1:0] size;
    logic       is_unsigned;
    logic       int_load;
    logic       int_store;
    logic       lui;
    logic       fp_load;
    logic       fp_store;
  } op_info_t;

  function automatic logic is_mem_state(input logic [3:0] s);
    return (s == S_MEM_STORE) || (s == S_MEM_LOAD);
  endfunction

endpackage

// File: rtl/mem_align_check.sv
// Combinational alignment check of the access size against the low address bits;
// a doubleword access on a 32-bit datapath is also reported as misaligned.
module mem_align_check
  import fsm_mem_access_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [1:0] mem_size,
  input  logic [2:0] addr_lo,
  output logic       misaligned
);

  always_comb begin
    misaligned = 1'b0;
    case (mem_size)
      SIZE_B:  misaligned = 1'b0;
      SIZE_H:  misaligned = addr_lo[0];
      SIZE_W:  misaligned = |addr_lo[1:0];
      default: misaligned = (|addr_lo) || (XLEN == 32);
    endcase
  end

endmodule

// File: rtl/fsm_mem_access.sv
// Load/store/lui sequencing FSM: decode, address, alignment check, bounded memory
// wait, writeback. Outputs decode only registered state and latched instruction fields.
module fsm_mem_access
  import fsm_mem_access_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 256,
  parameter int FP_EN   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] insn,
  input  logic [31:0] code,
  input  logic        start,
  input  logic        memory_done,
  input  logic [2:0]  addr_lo,
  output logic [1:0]  sel_rd,
  output logic        load_pc,
  output logic        load_regfile,
  output logic        load_fregfile,
  output logic        load_rs1,
  output logic        load_rs2,
  output logic        load_imm,
  output logic        load_alu,
  output logic        load_data_memory,
  output logic        memory_start,
  output logic        sel_mem_next,
  output logic        sel_mem_operation,
  output logic [1:0]  mem_size,
  output logic        mem_unsigned,
  output logic        done,
  output logic        fault
);

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);
  localparam logic        FP_ON     = (FP_EN != 0);

  logic [3:0]  state;
  logic [3:0]  state_nxt;
  logic [15:0] wait_cnt;
  op_info_t    op;
  logic        misaligned;
  logic        fp_illegal;
  logic        is_store;
  logic        unused_ok;

  assign unused_ok  = &{1'b0, insn[31:15], insn[11:7], code[31:14], code[12:9], code[7:1]};
  assign fp_illegal = (op.fp_load | op.fp_store) & ~FP_ON;
  assign is_store   = op.int_store | (op.fp_store & FP_ON);

  mem_align_check #(.XLEN(XLEN)) u_align (
    .mem_size   (op.size),
    .addr_lo    (addr_lo),
    .misaligned (misaligned)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Fields are captured while in DECODE so they are stable from EXECUTE onward.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= 16'd0;
      op       <= '0;
    end else begin
      wait_cnt <= is_mem_state(state) ? wait_cnt + 16'd1 : 16'd0;
      if (state == S_DECODE) begin
        op.size        <= insn[13:12];
        op.is_unsigned <= insn[14];
        op.int_load    <= code[CODE_LOAD];
        op.int_store   <= code[CODE_STORE];
        op.lui         <= code[CODE_LUI];
        op.fp_load     <= (insn[6:0] == OP_FP_LOAD);
        op.fp_store    <= (insn[6:0] == OP_FP_STORE);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (start) state_nxt = S_DECODE;
      S_DECODE:    state_nxt = code[CODE_LUI] ? S_WRITEBACK : S_EXECUTE;
      S_EXECUTE:   state_nxt = S_ALIGN;
      S_ALIGN: begin
        if (misaligned || fp_illegal) state_nxt = S_FAULT;
        else if (is_store)            state_nxt = S_MEM_STORE;
        else                          state_nxt = S_MEM_LOAD;
      end
      // Completion takes priority over an expiring wait budget.
      S_MEM_STORE, S_MEM_LOAD: begin
        if (memory_done)                 state_nxt = S_WRITEBACK;
        else if (wait_cnt == WAIT_LAST)  state_nxt = S_FAULT;
      end
      S_WRITEBACK: state_nxt = S_DONE;
      S_DONE:      state_nxt = S_IDLE;
      S_FAULT:     state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    sel_rd            = 2'b00;
    load_pc           = 1'b0;
    load_regfile      = 1'b0;
    load_fregfile     = 1'b0;
    load_rs1          = 1'b0;
    load_rs2          = 1'b0;
    load_imm          = 1'b0;
    load_alu          = 1'b0;
    load_data_memory  = 1'b0;
    memory_start      = 1'b0;
    sel_mem_next      = 1'b0;
    sel_mem_operation = 1'b0;
    mem_size          = 2'b00;
    mem_unsigned      = 1'b0;
    done              = 1'b0;
    fault             = 1'b0;
    case (state)
      S_DECODE: begin
        load_rs1 = 1'b1;
        load_rs2 = 1'b1;
        load_imm = 1'b1;
      end
      S_EXECUTE: load_alu = 1'b1;
      S_MEM_STORE: begin
        memory_start      = 1'b1;
        sel_mem_next      = 1'b1;
        sel_mem_operation = 1'b1;
      end
      S_MEM_LOAD: begin
        memory_start     = 1'b1;
        sel_mem_next     = 1'b1;
        load_data_memory = 1'b1;
      end
      S_WRITEBACK: begin
        load_pc       = 1'b1;
        load_regfile  = op.int_load | op.lui;
        load_fregfile = op.fp_load & FP_ON;
        sel_rd        = op.lui ? 2'b01 : 2'b00;
      end
      S_DONE: done = 1'b1;
      S_FAULT: begin
        done  = 1'b1;
        fault = 1'b1;
      end
      default: ;
    endcase
    if ((state == S_EXECUTE) || (state == S_ALIGN) || is_mem_state(state) ||
        (state == S_WRITEBACK)) begin
      mem_size     = op.size;
      mem_unsigned = op.is_unsigned;
    end
  end

endmodule

// File: tb/tb_fsm_mem_access.sv
// Directed bench for fsm_mem_access: dut a (XLEN 64, TIMEOUT 4, FP on) and
// dut b (XLEN 32, TIMEOUT 4, FP off) share stimulus; outputs are compared per cycle.
module tb_fsm_mem_access;

  // Output vector bit masks
  localparam logic [17:0] FLT = 18'h00001;
  localparam logic [17:0] DN  = 18'h00002;
  localparam logic [17:0] UNS = 18'h00004;
  localparam logic [17:0] S1  = 18'h00008;
  localparam logic [17:0] S2  = 18'h00010;
  localparam logic [17:0] S3  = 18'h00018;
  localparam logic [17:0] OPW = 18'h00020;
  localparam logic [17:0] NXT = 18'h00040;
  localparam logic [17:0] MST = 18'h00080;
  localparam logic [17:0] LDM = 18'h00100;
  localparam logic [17:0] ALU = 18'h00200;
  localparam logic [17:0] DEC = 18'h01C00;
  localparam logic [17:0] FRF = 18'h02000;
  localparam logic [17:0] RF  = 18'h04000;
  localparam logic [17:0] PC  = 18'h08000;
  localparam logic [17:0] LUI = 18'h10000;
  localparam logic [17:0] ML  = MST | NXT | LDM;
  localparam logic [17:0] MS  = MST | NXT | OPW;

  logic        clk = 1'b0;
  logic        reset, start, memory_done;
  logic [31:0] insn, code;
  logic [2:0]  addr_lo;
  int          checks = 0;
  int          errors = 0;

  logic [1:0] a_sel_rd, b_sel_rd, a_mem_size, b_mem_size;
  logic a_load_pc, a_load_regfile, a_load_fregfile, a_load_rs1, a_load_rs2, a_load_imm;
  logic a_load_alu, a_load_data_memory, a_memory_start, a_sel_mem_next, a_sel_mem_operation;
  logic a_mem_unsigned, a_done, a_fault;
  logic b_load_pc, b_load_regfile, b_load_fregfile, b_load_rs1, b_load_rs2, b_load_imm;
  logic b_load_alu, b_load_data_memory, b_memory_start, b_sel_mem_next, b_sel_mem_operation;
  logic b_mem_unsigned, b_done, b_fault;
  logic [17:0] o_a, o_b;

  assign o_a = {a_sel_rd, a_load_pc, a_load_regfile, a_load_fregfile, a_load_rs1, a_load_rs2,
                a_load_imm, a_load_alu, a_load_data_memory, a_memory_start, a_sel_mem_next,
                a_sel_mem_operation, a_mem_size, a_mem_unsigned, a_done, a_fault};
  assign o_b = {b_sel_rd, b_load_pc, b_load_regfile, b_load_fregfile, b_load_rs1, b_load_rs2,
                b_load_imm, b_load_alu, b_load_data_memory, b_memory_start, b_sel_mem_next,
                b_sel_mem_operation, b_mem_size, b_mem_unsigned, b_done, b_fault};

  always #5 clk = ~clk;

  fsm_mem_access #(.XLEN(64), .TIMEOUT(4), .FP_EN(1)) dut_a (
    .clk(clk), .reset(reset), .insn(insn), .code(code), .start(start),
    .memory_done(memory_done), .addr_lo(addr_lo),
    .sel_rd(a_sel_rd), .load_pc(a_load_pc), .load_regfile(a_load_regfile),
    .load_fregfile(a_load_fregfile), .load_rs1(a_load_rs1), .load_rs2(a_load_rs2),
    .load_imm(a_load_imm), .load_alu(a_load_alu), .load_data_memory(a_load_data_memory),
    .memory_start(a_memory_start), .sel_mem_next(a_sel_mem_next),
    .sel_mem_operation(a_sel_mem_operation), .mem_size(a_mem_size),
    .mem_unsigned(a_mem_unsigned), .done(a_done), .fault(a_fault)
  );

  fsm_mem_access #(.XLEN(32), .TIMEOUT(4), .FP_EN(0)) dut_b (
    .clk(clk), .reset(reset), .insn(insn), .code(code), .start(start),
    .memory_done(memory_done), .addr_lo(addr_lo),
    .sel_rd(b_sel_rd), .load_pc(b_load_pc), .load_regfile(b_load_regfile),
    .load_fregfile(b_load_fregfile), .load_rs1(b_load_rs1), .load_rs2(b_load_rs2),
    .load_imm(b_load_imm), .load_alu(b_load_alu), .load_data_memory(b_load_data_memory),
    .memory_start(b_memory_start), .sel_mem_next(b_sel_mem_next),
    .sel_mem_operation(b_sel_mem_operation), .mem_size(b_mem_size),
    .mem_unsigned(b_mem_unsigned), .done(b_done), .fault(b_fault)
  );

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; memory_done = 1'b0;
    insn = 32'h0000_0037; code = 32'h0000_2000; addr_lo = 3'b000;
    repeat (2) @(negedge clk);
    checks++;
    if (o_a !== 18'h0 || o_b !== 18'h0) begin
      errors++; $display("FAIL reset_state: a=%h b=%h expected 0", o_a, o_b);
    end
    start = 1'b1;
    @(negedge clk);
    checks++;
    if (o_a !== 18'h0) begin
      errors++; $display("FAIL reset_over_start: got %h expected 0", o_a);
    end
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    checks++;
    if (o_a !== 18'h0) begin
      errors++; $display("FAIL reset_release_idle: got %h expected 0", o_a);
    end
  endtask

  task automatic test_lw;
    logic [17:0] exp [0:9];
    exp = '{18'h0, DEC, ALU|S2, S2, ML|S2, ML|S2, ML|S2, PC|RF|S2, DN, 18'h0};
    insn = 32'h0000_2003; code = 32'h0000_0001; addr_lo = 3'b100;
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (o_a !== exp[k]) begin
        errors++; $display("FAIL lw cycle %0d: got %h expected %h", k, o_a, exp[k]);
      end
      start = (k == 0); memory_done = (k == 6);
      @(negedge clk);
    end
    memory_done = 1'b0;
  endtask

  task automatic test_sh_misaligned;
    logic [17:0] exp [0:5];
    exp = '{18'h0, DEC, ALU|S1, S1, FLT|DN, 18'h0};
    insn = 32'h0000_1023; code = 32'h0000_0100; addr_lo = 3'b001;
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (o_a !== exp[k]) begin
        errors++; $display("FAIL sh_misaligned cycle %0d: got %h expected %h", k, o_a, exp[k]);
      end
      start = (k == 0);
      @(negedge clk);
    end
  endtask

  task automatic test_timeout;
    logic [17:0] exp [0:10];
    for (int r = 0; r < 2; r++) begin
      if (r == 0) exp = '{18'h0, DEC, ALU|S3, S3, ML|S3, ML|S3, ML|S3, ML|S3, FLT|DN, 18'h0, 18'h0};
      else        exp = '{18'h0, DEC, ALU|S3, S3, ML|S3, ML|S3, ML|S3, ML|S3, PC|RF|S3, DN, 18'h0};
      insn = 32'h0000_3003; code = 32'h0000_0001; addr_lo = 3'b000;
      for (int k = 0; k < 11; k++) begin
        checks++;
        if (o_a !== exp[k]) begin
          errors++; $display("FAIL timeout run %0d cycle %0d: got %h expected %h", r, k, o_a, exp[k]);
        end
        if (r == 0 && k == 4) begin
          checks++;
          if (o_b !== (FLT|DN)) begin
            errors++; $display("FAIL ld_on_xlen32: got %h expected %h", o_b, FLT|DN);
          end
        end
        start = (k == 0); memory_done = (r == 1 && k == 7);
        @(negedge clk);
      end
    end
    memory_done = 1'b0;
  endtask

  task automatic test_fp;
    logic [17:0] exp [0:6];
    logic [17:0] s;
    for (int i = 0; i < 2; i++) begin
      s = (i == 0) ? S3 : S2;
      insn = (i == 0) ? 32'h0000_3007 : 32'h0000_2007;
      code = 32'h0; addr_lo = 3'b000;
      exp = '{18'h0, DEC, ALU|s, s, ML|s, PC|FRF|s, DN};
      for (int k = 0; k < 7; k++) begin
        checks++;
        if (o_a !== exp[k]) begin
          errors++; $display("FAIL fp_load %0d cycle %0d: got %h expected %h", i, k, o_a, exp[k]);
        end
        if (k == 4) begin
          checks++;
          if (o_b !== (FLT|DN)) begin
            errors++; $display("FAIL fp_disabled %0d: got %h expected %h", i, o_b, FLT|DN);
          end
        end
        start = (k == 0); memory_done = (k == 4);
        @(negedge clk);
      end
    end
    memory_done = 1'b0;
  endtask

  task automatic test_reset_mid_store;
    logic [17:0] exp [0:9];
    exp = '{18'h0, DEC, ALU|S3, S3, MS|S3, 18'h0, DEC, PC|RF|LUI, DN, 18'h0};
    insn = 32'h0000_3023; code = 32'h0000_0100; addr_lo = 3'b000;
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (o_a !== exp[k]) begin
        errors++; $display("FAIL reset_mid_store cycle %0d: got %h expected %h", k, o_a, exp[k]);
      end
      reset = (k == 4);
      start = (k == 0 || k == 5);
      if (k == 5) begin
        insn = 32'h0000_0037; code = 32'h0000_2000;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    logic [17:0] exp [0:14];
    exp = '{18'h0, DEC, ALU|UNS, UNS, ML|UNS, PC|RF|UNS, DN,
            18'h0, DEC, ALU|S2, S2, MS|S2, PC|S2, DN, 18'h0};
    insn = 32'h0000_4003; code = 32'h0000_0001; addr_lo = 3'b011;
    for (int k = 0; k < 15; k++) begin
      checks++;
      if (o_a !== exp[k]) begin
        errors++; $display("FAIL back_to_back cycle %0d: got %h expected %h", k, o_a, exp[k]);
      end
      start = (k == 0 || k == 6 || k == 7);
      memory_done = (k == 4 || k == 11);
      if (k == 7) begin
        insn = 32'h0000_2023; code = 32'h0000_0100; addr_lo = 3'b100;
      end
      @(negedge clk);
    end
    memory_done = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sh_misaligned();
    test_timeout();
    test_fp();
    test_reset_mid_store();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
